tipi_latch_seq: RTL and testbench
=================================

# tipi_latch_seq

Write sequencer for the four TIPI 8-bit transparent register latches: TD (TI data), TC (TI control), RD (RPi data) and RC (RPi control). It arbitrates write requests from the TI-bus side and the RPi side onto one shared 8-bit latch data bus. Each granted write runs a setup / strobe / hold sequence, so a latch never sees `din` change while its `le` is high.

## Interface

Parameters:
- `SETUP_CYCLES`, default 1: cycles `latch_din` is driven before `le` rises. Range 1..15.
- `STROBE_CYCLES`, default 1: cycles `le` stays high. Range 1..15.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `ti_req`  in  1  TI-side write request, level.
- `ti_sel`  in  1  TI-side target: 0 = TD, 1 = TC.
- `ti_data`  in  [0:7]  TI-side write data. Bit 0 is the MSB.
- `ti_ack`  out  1  one-cycle pulse: TI write complete.
- `pi_req`  in  1  RPi-side write request, level.
- `pi_sel`  in  1  RPi-side target: 0 = RD, 1 = RC.
- `pi_data`  in  [0:7]  RPi-side write data.
- `pi_ack`  out  1  one-cycle pulse: RPi write complete.
- `latch_din`  out  [0:7]  shared data bus to all four latches.
- `latch_le`  out  [0:3]  latch enables, in order TD, TC, RD, RC. At most one bit is high at any time.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation

- States:
  - IDLE
  - SETUP
  - STROBE
  - HOLD
- A 4-bit down-counter times SETUP and STROBE.
- IDLE:
  - Sample the requests.
  - On a grant, register the winner's data into `latch_din`.
  - Register the target index: TI uses {0, `ti_sel`}; RPi uses {1, `pi_sel`}.
  - Load the counter with `SETUP_CYCLES`-1 and go to SETUP.
  - With no request, stay in IDLE. `latch_din` holds its last value.
- SETUP: `latch_le` = 0. When the counter reaches 0, load `STROBE_CYCLES`-1 and go to STROBE.
- STROBE: `latch_le[target]` = 1. When the counter reaches 0, go to HOLD.
- HOLD:
  - Exactly 1 cycle.
  - `latch_le` = 0 and `latch_din` is unchanged.
  - The granted side's ack = 1.
  - Next state is IDLE.
- Request rules:
  - The requester holds `req`, `sel` and `data` stable from assertion until it sees ack.
  - `data` and `sel` are captured at grant; later changes are ignored.
- Lockout:
  - In the IDLE cycle directly after an ack, that side's `req` is ignored. This lets a registered requester drop `req`.
  - If its `req` is still high after the lockout cycle, it is treated as a new request.
- When both sides request in the same IDLE cycle, arbitration follows the Configuration section.
- Reset in any state takes effect at the next edge:
  - Outputs: state IDLE, `latch_le` = 0, `latch_din` = 8'h00, `ti_ack` = `pi_ack` = 0, `busy` = 0. The arbitration pointer favours TI.
  - An interrupted write issues no ack. The target latch content is undefined, and the requester re-issues the write after reset.

## Timing

- Call the IDLE cycle that samples the request cycle 0.
- SETUP occupies cycles 1..S, where S = `SETUP_CYCLES`.
- STROBE occupies cycles S+1..S+W, where W = `STROBE_CYCLES`.
- HOLD with ack is cycle S+W+1. With the defaults, ack arrives in cycle 3.
- Back-to-back throughput is one write per S+W+2 cycles, counting the IDLE cycle.
- `latch_din` is stable from cycle 1 through HOLD and stays stable in IDLE until the next grant. The setup and hold margins are at least S and 1 cycles respectively.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

- Macro: `TIPI_LATCH_SEQ_RR_EN`.
- Defined (round-robin):
  - A 1-bit pointer flips after every grant.
  - On simultaneous requests, the side not granted last wins.
  - Neither side waits more than one full write sequence.
- Undefined (fixed priority):
  - TI always wins simultaneous requests; the pointer logic is removed.
  - RPi can starve while TI keeps requesting.

## Test plan

- Reset → all outputs 0 and state IDLE. Then `ti_req`=1, `ti_sel`=0, `ti_data`=8'hAA → `latch_din`=8'hAA from cycle 1; `latch_le`=4'b1000 in cycle 2 only; `ti_ack` in cycle 3 only.
- `pi_req`=1, `pi_sel`=1, `pi_data`=8'h5A with `SETUP_CYCLES`=3, `STROBE_CYCLES`=2 → `latch_le`=4'b0001 in cycles 4–5; `pi_ack` in cycle 6; `latch_din`=8'h5A throughout cycles 1–6.
- TI and RPi request together, repeatedly, with the macro defined → grants alternate TI, RPi, TI, RPi. Without the macro → TI wins every contested grant.
- `ti_data` changes from 8'h12 to 8'h34 in cycle 1 → `latch_din` stays 8'h12 and the TD latch captures 8'h12.
- `reset` asserted during STROBE → next cycle `latch_le`=0, `latch_din`=8'h00, no ack; after release a new request completes normally.
- `ti_req` held high through its ack → lockout cycle ignores it, then a second TI write starts; `latch_le` never has two bits set at once.

Source files
------------

// File: rtl/tipi_latch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tipi_latch_seq
// Brief    : Setup/strobe/hold write sequencer for the four TIPI data/control
//            latches (TD, TC, RD, RC), arbitrating TI-bus and RPi writers.
//            Define TIPI_LATCH_SEQ_RR_EN for round-robin arbitration;
//            otherwise TI has fixed priority.
// Revision : 1.0
// ============================================================================
module tipi_latch_seq #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ti_req,
    input  logic       ti_sel,
    input  logic [0:7] ti_data,
    output logic       ti_ack,
    input  logic       pi_req,
    input  logic       pi_sel,
    input  logic [0:7] pi_data,
    output logic       pi_ack,
    output logic [0:7] latch_din,
    output logic [0:3] latch_le,
    output logic       busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_strobe = 2'd2;
    localparam logic [1:0] c_st_hold   = 2'd3;

    localparam logic [3:0] c_setup_load  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] c_strobe_load = 4'(STROBE_CYCLES - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [1:0] r_tgt;
    logic [1:0] w_tgt_nxt;
    logic [0:7] r_din;
    logic [0:7] w_din_nxt;
    logic [0:3] r_le;
    logic [0:3] w_le_nxt;
    logic       r_ti_ack;
    logic       w_ti_ack_nxt;
    logic       r_pi_ack;
    logic       w_pi_ack_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_ti_lock;
    logic       r_pi_lock;
    logic       w_ti_ok;
    logic       w_pi_ok;
    logic       w_grant;
    logic       w_pick_pi;

    // A side is deaf for the one IDLE cycle after its ack so it can drop req.
    assign w_ti_ok = ti_req & ~r_ti_lock;
    assign w_pi_ok = pi_req & ~r_pi_lock;
    assign w_grant = w_ti_ok | w_pi_ok;

`ifdef TIPI_LATCH_SEQ_RR_EN
    logic r_ptr;  // set: RPi wins the next contested grant

    assign w_pick_pi = w_pi_ok & (~w_ti_ok | r_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if ((r_state == c_st_idle) && w_grant) begin
            r_ptr <= ~w_pick_pi;
        end
    end
`else
    assign w_pick_pi = w_pi_ok & ~w_ti_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_tgt     <= 2'd0;
            r_din     <= 8'h00;
            r_le      <= 4'b0000;
            r_ti_ack  <= 1'b0;
            r_pi_ack  <= 1'b0;
            r_busy    <= 1'b0;
            r_ti_lock <= 1'b0;
            r_pi_lock <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tgt     <= w_tgt_nxt;
            r_din     <= w_din_nxt;
            r_le      <= w_le_nxt;
            r_ti_ack  <= w_ti_ack_nxt;
            r_pi_ack  <= w_pi_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_ti_lock <= r_ti_ack;
            r_pi_lock <= r_pi_ack;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_din_nxt   = r_din;
        case (r_state)
            c_st_idle: begin
                if (w_grant) begin
                    w_state_nxt = c_st_setup;
                    w_cnt_nxt   = c_setup_load;
                    w_tgt_nxt   = {w_pick_pi, (w_pick_pi ? pi_sel : ti_sel)};
                    w_din_nxt   = w_pick_pi ? pi_data : ti_data;
                end
            end
            c_st_setup: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_strobe;
                    w_cnt_nxt   = c_strobe_load;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            c_st_strobe: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_hold;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes from a flop.
    always_comb begin
        w_le_nxt     = 4'b0000;
        w_ti_ack_nxt = 1'b0;
        w_pi_ack_nxt = 1'b0;
        w_busy_nxt   = (w_state_nxt != c_st_idle);
        if (w_state_nxt == c_st_strobe) begin
            w_le_nxt[w_tgt_nxt] = 1'b1;
        end
        if (w_state_nxt == c_st_hold) begin
            w_ti_ack_nxt = ~w_tgt_nxt[1];
            w_pi_ack_nxt = w_tgt_nxt[1];
        end
    end

    assign ti_ack    = r_ti_ack;
    assign pi_ack    = r_pi_ack;
    assign latch_din = r_din;
    assign latch_le  = r_le;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tipi_latch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tipi_latch_seq
// Brief    : Self-checking bench for tipi_latch_seq (vector table, directed
//            corner sequences, random traffic against a timeline model).
// Revision : 1.0
// ============================================================================
module tb_tipi_latch_seq;

    localparam int S = 1;
    localparam int W = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ti_req, ti_sel, ti_ack;
    logic [0:7] ti_data;
    logic       pi_req, pi_sel, pi_ack;
    logic [0:7] pi_data;
    logic [0:7] latch_din;
    logic [0:3] latch_le;
    logic       busy;

    logic       b_pi_req, b_pi_sel, b_ti_ack, b_pi_ack, b_busy;
    logic [0:7] b_pi_data, b_din;
    logic [0:3] b_le;

    always #5 clk = ~clk;

    tipi_latch_seq dut (
        .clk(clk), .reset(rst),
        .ti_req(ti_req), .ti_sel(ti_sel), .ti_data(ti_data), .ti_ack(ti_ack),
        .pi_req(pi_req), .pi_sel(pi_sel), .pi_data(pi_data), .pi_ack(pi_ack),
        .latch_din(latch_din), .latch_le(latch_le), .busy(busy)
    );

    tipi_latch_seq #(.SETUP_CYCLES(3), .STROBE_CYCLES(2)) dut2 (
        .clk(clk), .reset(rst),
        .ti_req(1'b0), .ti_sel(1'b0), .ti_data(8'h00), .ti_ack(b_ti_ack),
        .pi_req(b_pi_req), .pi_sel(b_pi_sel), .pi_data(b_pi_data), .pi_ack(b_pi_ack),
        .latch_din(b_din), .latch_le(b_le), .busy(b_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst, treq, tsel;
        logic [7:0] tdat;
        logic       preq, psel;
        logic [7:0] pdat;
        logic [3:0] le;
        logic [7:0] din;
        logic       tack, pack, busy;
    } vec_t;

    // Timeline reference model: a write granted in cycle g owns cycles g+1..g+S+W+1.
    int         m_cyc, m_g;
    bit         m_act, m_fav_pi;
    logic [1:0] m_tgt;
    logic [7:0] m_din;
    logic [3:0] e_le;
    logic       e_ta, e_pa, e_busy;

    task automatic model_edge();
        int n, rel;
        bit idle, locked, t_ok, p_ok, pick_pi;
        n      = S + W;
        idle   = !m_act || (m_cyc >= m_g + n + 2);
        locked = m_act && (m_cyc == m_g + n + 2);
        if (rst) begin
            m_act    = 1'b0;
            m_din    = 8'h00;
            m_fav_pi = 1'b0;
        end else if (idle) begin
            t_ok = ti_req && !(locked && !m_tgt[1]);
            p_ok = pi_req && !(locked && m_tgt[1]);
`ifdef TIPI_LATCH_SEQ_RR_EN
            pick_pi = p_ok && (!t_ok || m_fav_pi);
`else
            pick_pi = p_ok && !t_ok;
`endif
            if (t_ok || p_ok) begin
                m_act    = 1'b1;
                m_g      = m_cyc;
                m_tgt    = {pick_pi, (pick_pi ? pi_sel : ti_sel)};
                m_din    = pick_pi ? pi_data : ti_data;
                m_fav_pi = !pick_pi;
            end
        end
        m_cyc++;
        rel    = m_cyc - m_g;
        e_le   = 4'b0000;
        e_ta   = 1'b0;
        e_pa   = 1'b0;
        e_busy = m_act && (rel >= 1) && (rel <= n + 1);
        if (m_act && (rel > S) && (rel <= n)) e_le = 4'b1000 >> m_tgt;
        if (m_act && (rel == n + 1)) begin
            e_ta = !m_tgt[1];
            e_pa = m_tgt[1];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tbl [23];
        logic [7:0] exp_first;
        bit         got_t, got_p, t_pend, p_pend;
        int         order, waited;

        rst = 1'b1; ti_req = 0; ti_sel = 0; ti_data = 8'h00;
        pi_req = 0; pi_sel = 0; pi_data = 8'h00;
        b_pi_req = 0; b_pi_sel = 0; b_pi_data = 8'h00;

        //            rst treq tsel tdat   preq psel pdat   le       din    ta pa busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b0000, 8'hAA, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b1000, 8'hAA, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b0000, 8'hAA, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b0000, 8'hAA, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b0000, 8'hAA, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h3C, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b0100, 8'h3C, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h3C, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 4'b0000, 8'h81, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 4'b0010, 8'h81, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h81, 4'b0000, 8'h81, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h81, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22, 4'b0000, 8'h11, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22, 4'b1000, 8'h11, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22, 4'b0000, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 4'b0000, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 4'b0000, 8'h22, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 4'b0001, 8'h22, 1'b0, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 4'b0000, 8'h22, 1'b0, 1'b1, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000, 8'h22, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 23; i++) begin
            rst = tbl[i].rst; ti_req = tbl[i].treq; ti_sel = tbl[i].tsel; ti_data = tbl[i].tdat;
            pi_req = tbl[i].preq; pi_sel = tbl[i].psel; pi_data = tbl[i].pdat;
            tick();
            check($sformatf("tbl%0d_le", i),   latch_le,  tbl[i].le);
            check($sformatf("tbl%0d_din", i),  latch_din, tbl[i].din);
            check($sformatf("tbl%0d_tack", i), ti_ack,    tbl[i].tack);
            check($sformatf("tbl%0d_pack", i), pi_ack,    tbl[i].pack);
            check($sformatf("tbl%0d_busy", i), busy,      tbl[i].busy);
        end

        // RPi write to RC with SETUP=3, STROBE=2
        b_pi_req = 1'b1; b_pi_sel = 1'b1; b_pi_data = 8'h5A;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("long_c%0d_le", k), b_le, (k == 4 || k == 5) ? 4'b0001 : 4'b0000);
            check($sformatf("long_c%0d_din", k), b_din, 8'h5A);
            check($sformatf("long_c%0d_pack", k), b_pi_ack, (k == 6) ? 1'b1 : 1'b0);
            check($sformatf("long_c%0d_busy", k), b_busy, (k <= 6) ? 1'b1 : 1'b0);
            if (k == 6) b_pi_req = 1'b0;
        end

        // Data changes after grant are ignored
        ti_req = 1'b1; ti_sel = 1'b0; ti_data = 8'h12;
        tick();
        check("capture_c1_din", latch_din, 8'h12);
        ti_data = 8'h34;
        tick();
        check("capture_c2_le", latch_le, 4'b1000);
        check("capture_c2_din", latch_din, 8'h12);
        tick();
        check("capture_c3_tack", ti_ack, 1'b1);
        check("capture_c3_din", latch_din, 8'h12);
        ti_req = 1'b0;
        tick();
        tick();

        // Reset in STROBE aborts the write without ack
        ti_req = 1'b1; ti_sel = 1'b1; ti_data = 8'h77;
        tick();
        tick();
        check("rst_strobe_le", latch_le, 4'b0100);
        rst = 1'b1;
        tick();
        check("rst_after_le", latch_le, 4'b0000);
        check("rst_after_din", latch_din, 8'h00);
        check("rst_after_acks", {ti_ack, pi_ack}, 2'b00);
        check("rst_after_busy", busy, 1'b0);
        rst = 1'b0;
        waited = 0;
        for (int k = 0; k < 10 && !ti_ack; k++) begin
            tick();
            waited++;
            check("rst_rec_onehot", ($countones(latch_le) <= 1), 1'b1);
        end
        check("rst_rec_ack", ti_ack, 1'b1);
        check("rst_rec_latency", waited, 3);
        check("rst_rec_din", latch_din, 8'h77);
        ti_req = 1'b0;
        tick();
        tick();

        // Arbitration: TI alone, then both contend
        ti_req = 1'b1; ti_sel = 1'b0; ti_data = 8'h0F;
        for (int k = 0; k < 10 && !ti_ack; k++) tick();
        check("solo_ti_ack", ti_ack, 1'b1);
        ti_req = 1'b0;
        tick();
        tick();
        ti_req = 1'b1; ti_sel = 1'b0; ti_data = 8'hA1;
        pi_req = 1'b1; pi_sel = 1'b0; pi_data = 8'hB2;
        tick();
`ifdef TIPI_LATCH_SEQ_RR_EN
        exp_first = 8'hB2;
`else
        exp_first = 8'hA1;
`endif
        check("contest_din", latch_din, exp_first);
        got_t = 0; got_p = 0; order = 0;
        for (int k = 0; k < 20 && !(got_t && got_p); k++) begin
            tick();
            check("contest_onehot", ($countones(latch_le) <= 1), 1'b1);
            if (ti_ack && !got_t) begin
                got_t = 1; ti_req = 1'b0;
                if (order == 0) order = 1;
            end
            if (pi_ack && !got_p) begin
                got_p = 1; pi_req = 1'b0;
                if (order == 0) order = 2;
            end
        end
        check("contest_both_acked", {got_t, got_p}, 2'b11);
        check("contest_order", order, (exp_first == 8'hB2) ? 2 : 1);
        tick();
        tick();

        // Random traffic against the model
        m_cyc = 0; m_g = 0; m_act = 0; m_fav_pi = 0; m_tgt = 2'd0; m_din = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        t_pend = 0; p_pend = 0;
        for (int i = 0; i < 3000; i++) begin
            check("rnd_le", latch_le, e_le);
            check("rnd_din", latch_din, m_din);
            check("rnd_tack", ti_ack, e_ta);
            check("rnd_pack", pi_ack, e_pa);
            check("rnd_busy", busy, e_busy);
            check("rnd_onehot", ($countones(latch_le) <= 1), 1'b1);
            rst = ($urandom_range(0, 199) == 0);
            if (ti_ack) begin
                if ($urandom_range(0, 1) == 0) begin
                    ti_req = 1'b0; t_pend = 0;
                end else begin
                    ti_sel = 1'($urandom); ti_data = 8'($urandom);
                end
            end else if (!t_pend && $urandom_range(0, 3) == 0) begin
                ti_req = 1'b1; t_pend = 1;
                ti_sel = 1'($urandom); ti_data = 8'($urandom);
            end
            if (pi_ack) begin
                if ($urandom_range(0, 1) == 0) begin
                    pi_req = 1'b0; p_pend = 0;
                end else begin
                    pi_sel = 1'($urandom); pi_data = 8'($urandom);
                end
            end else if (!p_pend && $urandom_range(0, 3) == 0) begin
                pi_req = 1'b1; p_pend = 1;
                pi_sel = 1'($urandom); pi_data = 8'($urandom);
            end
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
